// File: rtl/dor_route_unit.sv
// Dimension-order (XY/YX) wormhole route unit with a single registered flit stage.
// Optional packet counter port pkt_cnt_o when DOR_ROUTE_PKT_CNT_EN is defined.
module dor_route_unit #(
  parameter int COL_CORD    = 0,
  parameter int ROW_CORD    = 0,
  parameter int COL_ADDR_W  = 4,
  parameter int ROW_ADDR_W  = 4,
  parameter int OUT_N_W     = 3,
  parameter int FLIT_ID_W   = 2,
  parameter int DATA_W      = 16,
  parameter int ROUTE_ORDER = 0
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [DATA_W-1:0]  flit_i,
  input  logic               valid_i,
  output logic               ready_o,
  output logic [DATA_W-1:0]  flit_o,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [OUT_N_W-1:0] out_chan_sel_o,
  output logic               busy_o,
`ifdef DOR_ROUTE_PKT_CNT_EN
  output logic [15:0]        pkt_cnt_o,
`endif
  output logic               err_o
);

  // state  | meaning
  // IDLE   | no packet open; HEAD/SINGLE accepted, BODY/TAIL are errors
  // LOCKED | packet open; BODY/TAIL follow the locked route, HEAD/SINGLE are errors
  typedef enum logic {IDLE, LOCKED} state_t;

  localparam logic [FLIT_ID_W-1:0] ID_HEAD   = FLIT_ID_W'(2'b10);
  localparam logic [FLIT_ID_W-1:0] ID_BODY   = FLIT_ID_W'(2'b00);
  localparam logic [FLIT_ID_W-1:0] ID_TAIL   = FLIT_ID_W'(2'b11);
  localparam logic [FLIT_ID_W-1:0] ID_SINGLE = FLIT_ID_W'(2'b01);

  localparam logic [OUT_N_W-1:0] PORT_RES   = OUT_N_W'(0);
  localparam logic [OUT_N_W-1:0] PORT_LEFT  = OUT_N_W'(1);
  localparam logic [OUT_N_W-1:0] PORT_UP    = OUT_N_W'(2);
  localparam logic [OUT_N_W-1:0] PORT_RIGHT = OUT_N_W'(3);
  localparam logic [OUT_N_W-1:0] PORT_DOWN  = OUT_N_W'(4);

  localparam logic [COL_ADDR_W-1:0] COL_HERE = COL_ADDR_W'(COL_CORD);
  localparam logic [ROW_ADDR_W-1:0] ROW_HERE = ROW_ADDR_W'(ROW_CORD);

  state_t                state;
  logic [FLIT_ID_W-1:0]  flit_id;
  logic [COL_ADDR_W-1:0] col_addr;
  logic [ROW_ADDR_W-1:0] row_addr;
  logic [OUT_N_W-1:0]    col_port;
  logic [OUT_N_W-1:0]    row_port;
  logic [OUT_N_W-1:0]    route_sel;
  logic                  in_xfer;
  logic                  out_xfer;
  logic                  is_head;
  logic                  is_tail;
  logic                  fwd;
  logic                  drop;

  assign flit_id  = flit_i[DATA_W-1 -: FLIT_ID_W];
  assign row_addr = flit_i[ROW_ADDR_W-1:0];
  assign col_addr = flit_i[ROW_ADDR_W+COL_ADDR_W-1:ROW_ADDR_W];

  assign ready_o  = !valid_o || ready_i;
  assign in_xfer  = valid_i && ready_o;
  assign out_xfer = valid_o && ready_i;

  assign is_head = (flit_id == ID_HEAD);
  assign is_tail = (flit_id == ID_TAIL);

  always_comb begin
    col_port  = (col_addr > COL_HERE) ? PORT_RIGHT : PORT_LEFT;
    row_port  = (row_addr < ROW_HERE) ? PORT_UP : PORT_DOWN;
    route_sel = PORT_RES;
    if (ROUTE_ORDER == 0) begin
      if (col_addr != COL_HERE)      route_sel = col_port;
      else if (row_addr != ROW_HERE) route_sel = row_port;
    end else begin
      if (row_addr != ROW_HERE)      route_sel = row_port;
      else if (col_addr != COL_HERE) route_sel = col_port;
    end
  end

  always_comb begin
    fwd = 1'b0;
    if (in_xfer) begin
      if (state == IDLE) fwd = is_head || (flit_id == ID_SINGLE);
      else               fwd = is_tail || (flit_id == ID_BODY);
    end
  end

  assign drop = in_xfer && !fwd;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state          <= IDLE;
      flit_o         <= '0;
      valid_o        <= 1'b0;
      out_chan_sel_o <= '0;
      busy_o         <= 1'b0;
      err_o          <= 1'b0;
`ifdef DOR_ROUTE_PKT_CNT_EN
      pkt_cnt_o      <= '0;
`endif
    end else begin
      if (fwd) begin
        flit_o  <= flit_i;
        valid_o <= 1'b1;
        // inside a packet the register already holds the locked route
        if (state == IDLE) out_chan_sel_o <= route_sel;
      end else if (out_xfer) begin
        valid_o <= 1'b0;
      end
      if (drop) err_o <= 1'b1;
`ifdef DOR_ROUTE_PKT_CNT_EN
      if (fwd && !is_head && (state == IDLE || is_tail) && pkt_cnt_o != 16'hFFFF)
        pkt_cnt_o <= pkt_cnt_o + 16'd1;
`endif
      case (state)
        IDLE: begin
          if (fwd && is_head) begin
            state  <= LOCKED;
            busy_o <= 1'b1;
          end
        end
        LOCKED: begin
          if (fwd && is_tail) begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dor_route_unit.sv
// Randomised + directed bench for dor_route_unit; XY and YX instances share one stimulus stream.
module tb_dor_route_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] flit_i = '0;
  logic        valid_i = 1'b0;
  logic        ready_i = 1'b1;
  logic        ready_o [2];
  logic [15:0] flit_o  [2];
  logic        valid_o [2];
  logic [2:0]  sel     [2];
  logic        busy_o  [2];
  logic        err_o   [2];
`ifdef DOR_ROUTE_PKT_CNT_EN
  logic [15:0] pkt_cnt [2];
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    dor_route_unit #(.COL_CORD(1), .ROW_CORD(1), .ROUTE_ORDER(g)) dut (
      .clk_i(clk), .rst_i(rst), .flit_i(flit_i), .valid_i(valid_i),
      .ready_o(ready_o[g]), .flit_o(flit_o[g]), .valid_o(valid_o[g]),
      .ready_i(ready_i), .out_chan_sel_o(sel[g]), .busy_o(busy_o[g]),
`ifdef DOR_ROUTE_PKT_CNT_EN
      .pkt_cnt_o(pkt_cnt[g]),
`endif
      .err_o(err_o[g])
    );
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // port from signed offsets to this switch at (1,1)
  function automatic int route(input logic [15:0] f, input int order);
    int dc = int'(f[7:4]) - 1;
    int dr = int'(f[3:0]) - 1;
    int h  = (dc > 0) ? 3 : ((dc < 0) ? 1 : 0);
    int v  = (dr < 0) ? 2 : ((dr > 0) ? 4 : 0);
    return (order == 0) ? ((h != 0) ? h : v) : ((v != 0) ? v : h);
  endfunction

  // behavioural model and per-cycle compare, sampled 1 time unit before each rising edge
  bit          m_valid, m_lock, m_err, m_fresh;
  logic [15:0] m_flit;
  int          m_sel [2];
  int          m_lsel[2];
  int          m_cnt;

  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (rst) begin
        for (int k = 0; k < 2; k++) begin
          chk("rst_valid", valid_o[k], 0);
          chk("rst_flit", flit_o[k], 0);
          chk("rst_sel", sel[k], 0);
          chk("rst_busy", busy_o[k], 0);
          chk("rst_err", err_o[k], 0);
        end
        m_valid = 0; m_lock = 0; m_err = 0; m_fresh = 1; m_flit = '0; m_cnt = 0;
        m_sel = '{0, 0}; m_lsel = '{0, 0};
      end else begin
        bit in_x;
        logic [1:0] t;
        bit ok;
        for (int k = 0; k < 2; k++) begin
          chk("ready_o", ready_o[k], int'(!m_valid || ready_i));
          chk("valid_o", valid_o[k], int'(m_valid));
          chk("busy_o", busy_o[k], int'(m_lock));
          chk("err_o", err_o[k], int'(m_err));
          if (m_valid || m_fresh) begin
            chk("flit_o", flit_o[k], m_flit);
            chk("sel", sel[k], m_sel[k]);
          end
`ifdef DOR_ROUTE_PKT_CNT_EN
          chk("pkt_cnt", pkt_cnt[k], m_cnt);
`endif
        end
        in_x = valid_i && (!m_valid || ready_i);
        if (m_valid && ready_i) m_valid = 0;
        if (in_x) begin
          t  = flit_i[15:14];
          ok = m_lock ? (t == 2'b00 || t == 2'b11) : (t == 2'b10 || t == 2'b01);
          if (!ok) m_err = 1;
          else begin
            m_valid = 1; m_fresh = 0; m_flit = flit_i;
            for (int k = 0; k < 2; k++) begin
              m_sel[k] = m_lock ? m_lsel[k] : route(flit_i, k);
              if (t == 2'b10) m_lsel[k] = m_sel[k];
            end
            if (t == 2'b10) m_lock = 1;
            if (t == 2'b11) m_lock = 0;
            if ((t == 2'b11 || t == 2'b01) && m_cnt < 16'hFFFF) m_cnt++;
          end
        end
      end
    end
  end

  // drive a flit from the next falling edge; returns at the rising edge that accepts it
  task automatic send(input logic [15:0] f);
    int n = 0;
    @(negedge clk);
    valid_i = 1'b1;
    flit_i  = f;
    #4;
    while (!ready_o[0] && n < 50) begin
      @(negedge clk);
      #4;
      n++;
    end
    if (!ready_o[0]) begin
      miscompares++;
      $display("FAIL send_timeout: ready_o stuck at 0 for flit %0h", f);
    end
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    valid_i = 1'b0;
  endtask

  logic [15:0] singles [4] = '{16'h4033, 16'h4011, 16'h4012, 16'h4010};
  int          single_exp [4] = '{3, 0, 4, 2};

  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk("reset_valid", valid_o[0], 0);
    chk("reset_busy", busy_o[0], 0);
    chk("reset_ready", ready_o[0], 1);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      send(singles[i]);
      #1;
      chk("single_sel", sel[0], single_exp[i]);
      chk("single_flit", flit_o[0], singles[i]);
      chk("single_valid", valid_o[0], 1);
    end

    send(16'h4030);
    #1;
    chk("yx_sel", sel[1], 2);
    chk("xy_sel", sel[0], 3);

    send(16'h8003);
    #1;
    chk("pkt_head_sel", sel[0], 1);
    chk("pkt_head_busy", busy_o[0], 1);
    send(16'h0ABC);
    #1;
    chk("pkt_body_sel", sel[0], 1);
    chk("pkt_body_busy", busy_o[0], 1);
    send(16'hC123);
    #1;
    chk("pkt_tail_sel", sel[0], 1);
    chk("pkt_tail_busy", busy_o[0], 0);
    idle();

    // backpressure: head held for 3 cycles, then body follows
    send(16'h8003);
    @(negedge clk);
    ready_i = 1'b0;
    flit_i  = 16'h0222;
    repeat (3) begin
      #4;
      chk("bp_ready", ready_o[0], 0);
      chk("bp_flit", flit_o[0], 16'h8003);
      chk("bp_sel", sel[0], 1);
      @(negedge clk);
    end
    ready_i = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_body_flit", flit_o[0], 16'h0222);
    chk("bp_body_sel", sel[0], 1);
    send(16'hC000);
    idle();

    send(16'h0011);
    #1;
    chk("err_body_valid", valid_o[0], 0);
    chk("err_body_err", err_o[0], 1);
    send(16'h8003);
    send(16'h8011);
    #1;
    chk("err_head_valid", valid_o[0], 0);
    chk("err_head_busy", busy_o[0], 1);
    chk("err_head_err", err_o[0], 1);
    send(16'hC000);
    #1;
    chk("err_tail_sel", sel[0], 1);
    chk("err_tail_busy", busy_o[0], 0);
    idle();

    send(16'h8003);
    @(negedge clk);
    valid_i = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_valid", valid_o[0], 0);
    chk("midrst_flit", flit_o[0], 0);
    chk("midrst_sel", sel[0], 0);
    chk("midrst_busy", busy_o[0], 0);
    chk("midrst_err", err_o[0], 0);
    @(negedge clk);
    rst = 1'b0;
    send(16'h8033);
    #1;
    chk("post_rst_sel", sel[0], 3);
    chk("post_rst_busy", busy_o[0], 1);
    send(16'hC000);
    idle();

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst     = ($urandom_range(0, 299) == 0);
      valid_i = $urandom_range(0, 2) != 0;
      ready_i = $urandom_range(0, 3) != 0;
      flit_i  = {2'($urandom), 6'($urandom), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
    end
    @(negedge clk);
    rst = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b1;
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
